// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared encodings for the ysyx_25020047 load/store unit.
package ysyx_25020047_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Malformed or misaligned request: reported without touching the bus.
    function automatic logic req_is_bad(input logic rd, input logic wr,
                                        input logic [1:0] size, input logic [1:0] off);
        return (rd == wr)
            || (size == 2'd3)
            || ((size == SZ_H) && off[0])
            || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane formatting: load extract/extend, store replication and strobes.
module ysyx_25020047_lsu_align
    import ysyx_25020047_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed lane, then extend and build store lanes by size.
    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        ld_byte  = shifted[7:0];
        ld_half  = off[1] ? rdata[31:16] : rdata[15:0];
        ld_data  = '0;
        st_wdata = '0;
        st_wstrb = '0;
        case (size)
            SZ_B: begin
                ld_data  = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            SZ_H: begin
                ld_data  = {{16{~is_unsigned & ld_half[15]}}, ld_half};
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            SZ_W: begin
                ld_data  = rdata;
                st_wdata = wdata;
                st_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit: one request at a time, word-aligned bus with strobes.
module ysyx_25020047_lsu
    import ysyx_25020047_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] ld_data;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    ysyx_25020047_lsu_align u_align (
        .size        (size_q),
        .off         (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_resp_rdata),
        .ld_data     (ld_data),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb)
    );

    // Next-state, request latch, timeout count and response formation.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        size_d          = size_q;
        uns_d           = uns_q;
        we_d            = we_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        resp_valid_d    = 1'b0;
        resp_err_d      = 1'b0;
        resp_rdata_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    we_d    = req_write;
                    if (req_is_bad(req_read, req_write, req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d         = ST_REQ;
                        mem_req_valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d         = ST_WAIT;
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A bus response in the last allowed cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : ld_data;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            we_q            <= 1'b0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            we_q            <= we_d;
            cnt_q           <= cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_rdata_q    <= resp_rdata_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE) && rst_n;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_q[31:2], 2'b00};
    assign mem_req_wdata = st_wdata;
    assign mem_req_wstrb = we_q ? st_wstrb : 4'b0000;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed self-checking bench for ysyx_25020047_lsu.
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    // Per-transaction observations filled in by run_txn.
    int          o_lat, o_nreq, o_hs;
    logic [31:0] o_rdata, o_baddr, o_bwdata;
    logic [3:0]  o_bwstrb;
    logic        o_err, o_bwe, o_ready0;
    bit          o_stable;

    always #5 clk = ~clk;

    ysyx_25020047_lsu #(.TIMEOUT(255)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // Present one request and play the bus side: ready after ready_lat REQ cycles,
    // response (if give_resp) the cycle after the handshake. Cycle 0 is the accept cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                           input int ready_lat, input bit give_resp, input logic [31:0] word);
        o_lat = -1; o_nreq = 0; o_hs = -1; o_stable = 1'b1;
        o_rdata = 'x; o_err = 'x;
        o_baddr = '0; o_bwdata = '0; o_bwstrb = '0; o_bwe = 1'b0;
        @(negedge clk);
        o_ready0 = req_ready;
        req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr;
        req_wdata = wd; req_size = sz; req_unsigned = uns;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = word;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
                break;
            end
            if (mem_req_valid) begin
                o_nreq++;
                if (o_nreq == 1) begin
                    o_baddr = mem_req_addr; o_bwdata = mem_req_wdata;
                    o_bwstrb = mem_req_wstrb; o_bwe = mem_req_we;
                end else if (mem_req_addr !== o_baddr || mem_req_wdata !== o_bwdata ||
                             mem_req_wstrb !== o_bwstrb || mem_req_we !== o_bwe) begin
                    o_stable = 1'b0;
                end
                mem_req_ready = (o_nreq > ready_lat);
                if (mem_req_ready) o_hs = c;
            end else begin
                mem_req_ready = 1'b0;
            end
            mem_resp_valid = give_resp && (o_hs > 0) && (c == o_hs + 1);
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin $display("FAIL rst_req_ready got %b exp 0", req_ready); n_err++; end
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid got %b exp 0", resp_valid); n_err++; end
        n_vec++; if (resp_err !== 1'b0) begin $display("FAIL rst_resp_err got %b exp 0", resp_err); n_err++; end
        n_vec++; if (resp_rdata !== 32'h0) begin $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); n_err++; end
        n_vec++; if (mem_req_valid !== 1'b0) begin $display("FAIL rst_mem_req_valid got %b exp 0", mem_req_valid); n_err++; end
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_vec++; if (req_ready !== 1'b1) begin $display("FAIL rst_release_ready got %b exp 1", req_ready); n_err++; end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL rst_stale_resp got %b exp 0", resp_valid); n_err++; end
    endtask

    task automatic test_loads;
        logic [31:0] a  [8] = '{32'h8000_0004, 32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000};
        logic [1:0]  s  [8] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic        u  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] w  [8] = '{32'hDEAD_BEEF, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h8001_0000,
                                32'h8001_0000, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_7BCC};
        logic [31:0] e  [8] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                32'h0000_8001, 32'hFFFF_FFBB, 32'h0000_00CC, 32'h0000_7BCC};
        logic [31:0] ea;
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 1'b0, a[i], 32'h0, s[i], u[i], 0, 1'b1, w[i]);
            ea = {a[i][31:2], 2'b00};
            n_vec++; if (o_rdata !== e[i]) begin $display("FAIL load%0d_rdata got %h exp %h", i, o_rdata, e[i]); n_err++; end
            n_vec++; if (o_err !== 1'b0) begin $display("FAIL load%0d_err got %b exp 0", i, o_err); n_err++; end
            n_vec++; if (o_lat != 3) begin $display("FAIL load%0d_latency got %0d exp 3", i, o_lat); n_err++; end
            n_vec++; if (o_baddr !== ea) begin $display("FAIL load%0d_bus_addr got %h exp %h", i, o_baddr, ea); n_err++; end
            n_vec++; if (o_bwstrb !== 4'b0000 || o_bwe !== 1'b0) begin
                $display("FAIL load%0d_bus_wr got we=%b wstrb=%b exp we=0 wstrb=0000", i, o_bwe, o_bwstrb); n_err++; end
        end
    endtask

    task automatic test_stores;
        logic [31:0] a  [4] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0008, 32'h8000_0003};
        logic [31:0] d  [4] = '{32'h1234_56AB, 32'h1234_56AB, 32'hCAFE_F00D, 32'h0000_0071};
        logic [1:0]  s  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [31:0] ew [4] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'hCAFE_F00D, 32'h7171_7171};
        logic [3:0]  es [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
        logic [31:0] ea [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0008, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, 1'b1, a[i], d[i], s[i], 1'b0, 0, 1'b1, 32'hFFFF_FFFF);
            n_vec++; if (o_bwdata !== ew[i]) begin $display("FAIL store%0d_wdata got %h exp %h", i, o_bwdata, ew[i]); n_err++; end
            n_vec++; if (o_bwstrb !== es[i]) begin $display("FAIL store%0d_wstrb got %b exp %b", i, o_bwstrb, es[i]); n_err++; end
            n_vec++; if (o_bwe !== 1'b1) begin $display("FAIL store%0d_we got %b exp 1", i, o_bwe); n_err++; end
            n_vec++; if (o_baddr !== ea[i]) begin $display("FAIL store%0d_addr got %h exp %h", i, o_baddr, ea[i]); n_err++; end
            n_vec++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin
                $display("FAIL store%0d_ack got rdata=%h err=%b exp rdata=0 err=0", i, o_rdata, o_err); n_err++; end
            n_vec++; if (o_lat != 3) begin $display("FAIL store%0d_latency got %0d exp 3", i, o_lat); n_err++; end
        end
    endtask

    task automatic test_errors;
        logic        rd [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        wr [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] a  [6] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0003};
        logic [1:0]  s  [6] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1};
        for (int i = 0; i < 6; i++) begin
            run_txn(rd[i], wr[i], a[i], 32'hFFFF_FFFF, s[i], 1'b0, 0, 1'b1, 32'h1234_5678);
            n_vec++; if (o_lat != 1) begin $display("FAIL err%0d_latency got %0d exp 1", i, o_lat); n_err++; end
            n_vec++; if (o_err !== 1'b1) begin $display("FAIL err%0d_flag got %b exp 1", i, o_err); n_err++; end
            n_vec++; if (o_rdata !== 32'h0) begin $display("FAIL err%0d_rdata got %h exp 0", i, o_rdata); n_err++; end
            n_vec++; if (o_nreq != 0) begin $display("FAIL err%0d_bus_req got %0d cycles exp 0", i, o_nreq); n_err++; end
        end
    endtask

    task automatic test_stall;
        run_txn(1'b0, 1'b1, 32'h8000_0012, 32'h0000_BEEF, 2'd1, 1'b0, 5, 1'b1, 32'h0);
        n_vec++; if (o_nreq != 6) begin $display("FAIL stall_req_cycles got %0d exp 6", o_nreq); n_err++; end
        n_vec++; if (o_stable !== 1'b1) begin $display("FAIL stall_bus_stable got %b exp 1", o_stable); n_err++; end
        n_vec++; if (o_bwstrb !== 4'b1100 || o_bwdata !== 32'hBEEF_BEEF) begin
            $display("FAIL stall_bus_data got wstrb=%b wdata=%h exp 1100 beefbeef", o_bwstrb, o_bwdata); n_err++; end
        n_vec++; if (o_lat != 8) begin $display("FAIL stall_latency got %0d exp 8", o_lat); n_err++; end
        n_vec++; if (o_err !== 1'b0) begin $display("FAIL stall_err got %b exp 0", o_err); n_err++; end
    endtask

    task automatic test_timeout;
        run_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 2'd2, 1'b0, 0, 1'b0, 32'h7777_7777);
        n_vec++; if (o_hs != 1) begin $display("FAIL to_handshake got cycle %0d exp 1", o_hs); n_err++; end
        // WAIT entered at cycle 2; response forced 255 cycles later.
        n_vec++; if (o_lat != 257) begin $display("FAIL to_latency got %0d exp 257", o_lat); n_err++; end
        n_vec++; if (o_err !== 1'b1) begin $display("FAIL to_err got %b exp 1", o_err); n_err++; end
        n_vec++; if (o_rdata !== 32'h0) begin $display("FAIL to_rdata got %h exp 0", o_rdata); n_err++; end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL to_pulse_width got %b exp 0", resp_valid); n_err++; end
        n_vec++; if (req_ready !== 1'b1) begin $display("FAIL to_back_idle got %b exp 1", req_ready); n_err++; end
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL to_late_resp got %b exp 0", resp_valid); n_err++; end
        n_vec++; if (req_ready !== 1'b1) begin $display("FAIL to_late_ready got %b exp 1", req_ready); n_err++; end
    endtask

    task automatic test_back_to_back;
        run_txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h0000_0001);
        run_txn(1'b0, 1'b1, 32'h8000_0101, 32'h0000_00EE, 2'd0, 1'b0, 0, 1'b1, 32'h0);
        n_vec++; if (o_ready0 !== 1'b1) begin $display("FAIL b2b_ready1 got %b exp 1", o_ready0); n_err++; end
        n_vec++; if (o_bwstrb !== 4'b0010) begin $display("FAIL b2b_wstrb got %b exp 0010", o_bwstrb); n_err++; end
        run_txn(1'b1, 1'b1, 32'h8000_0100, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h0);
        n_vec++; if (o_ready0 !== 1'b1 || o_lat != 1) begin
            $display("FAIL b2b_err got ready=%b lat=%0d exp ready=1 lat=1", o_ready0, o_lat); n_err++; end
        run_txn(1'b1, 1'b0, 32'h8000_0102, 32'h0, 2'd1, 1'b1, 0, 1'b1, 32'hF00D_0000);
        n_vec++; if (o_ready0 !== 1'b1 || o_rdata !== 32'h0000_F00D) begin
            $display("FAIL b2b_lhu got ready=%b rdata=%h exp ready=1 rdata=0000f00d", o_ready0, o_rdata); n_err++; end
    endtask

    task automatic test_reset_mid;
        // Reset while REQ is pending: mem_req_valid must drop at the reset edge.
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_addr = 32'h8000_0020; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (mem_req_valid !== 1'b1) begin $display("FAIL rmid_req_valid got %b exp 1", mem_req_valid); n_err++; end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_req_valid !== 1'b0) begin $display("FAIL rmid_req_drop got %b exp 0", mem_req_valid); n_err++; end
        rst_n = 1'b1;
        @(negedge clk);
        // Reset while in WAIT: transaction abandoned, no response.
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            $display("FAIL rmid_in_reset got resp=%b ready=%b exp 0 0", resp_valid, req_ready); n_err++; end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin $display("FAIL rmid_ready_after got %b exp 1", req_ready); n_err++; end
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL rmid_no_resp got %b exp 0", resp_valid); n_err++; end
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_vec++; if (resp_valid !== 1'b0) begin $display("FAIL rmid_stale_resp got %b exp 0", resp_valid); n_err++; end
        run_txn(1'b1, 1'b0, 32'h8000_0024, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h0BAD_F00D);
        n_vec++; if (o_lat != 3 || o_rdata !== 32'h0BAD_F00D || o_err !== 1'b0) begin
            $display("FAIL rmid_next_lw got lat=%0d rdata=%h err=%b exp 3 0badf00d 0", o_lat, o_rdata, o_err); n_err++; end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_errors;
        test_stall;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got no completion exp finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
